button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 118 +++++++++++
 tb/tb_button_event_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder: debounces five pushbuttons and emits held levels plus
// press, release, long-press and U-while-C chord pulses.
module button_event_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    output logic [4:0] held,
    output logic [4:0] press,
    output logic [4:0] released,
    output logic [4:0] long_press,
    output logic       chord_uc
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] L_PRE  = LW'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    logic [4:0] raw, sync1, sync, press_nx;

    assign raw = {btnD, btnR, btnL, btnU, btnC};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
        end
    end

    for (genvar i = 0; i < 5; i++) begin : g_btn
        state_t        state, state_nx;
        logic [DW-1:0] dcnt, dcnt_nx;
        logic [LW-1:0] lcnt, lcnt_nx;
        logic          p_nx, r_nx, l_nx, p_q, r_q, l_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= IDLE;
                dcnt  <= '0;
                lcnt  <= '0;
                p_q   <= 1'b0;
                r_q   <= 1'b0;
                l_q   <= 1'b0;
            end else begin
                state <= state_nx;
                dcnt  <= dcnt_nx;
                lcnt  <= lcnt_nx;
                p_q   <= p_nx;
                r_q   <= r_nx;
                l_q   <= l_nx;
            end
        end

        always_comb begin
            state_nx = state;
            dcnt_nx  = dcnt;
            lcnt_nx  = lcnt;
            p_nx     = 1'b0;
            r_nx     = 1'b0;
            l_nx     = 1'b0;
            case (state)
                IDLE: if (sync[i]) begin
                    state_nx = PRESS_WAIT;
                    dcnt_nx  = '0;
                end
                PRESS_WAIT: if (!sync[i]) begin
                    state_nx = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_nx = HELD;
                    p_nx     = 1'b1;
                    lcnt_nx  = '0;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
                HELD: if (!sync[i]) begin
                    state_nx = REL_WAIT;
                    dcnt_nx  = '0;
                end else if (lcnt != L_LAST) begin
                    lcnt_nx = lcnt + 1'b1;
                    l_nx    = (lcnt == L_PRE);
                end
                // a bounce back to HELD leaves the long counter untouched
                REL_WAIT: if (sync[i]) begin
                    state_nx = HELD;
                end else if (dcnt == D_LAST) begin
                    state_nx = IDLE;
                    r_nx     = 1'b1;
                end else begin
                    dcnt_nx = dcnt + 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end

        assign press_nx[i]   = p_nx;
        assign held[i]       = (state == HELD) || (state == REL_WAIT);
        assign press[i]      = p_q;
        assign released[i]   = r_q;
        assign long_press[i] = l_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chord_uc <= 1'b0;
        else        chord_uc <= press_nx[1] & held[0];
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed scenarios checked every cycle against a
// run-length debounce model, plus literal timing checks on recorded pulses.
module tb_button_event_decoder;
    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0, rst_n = 1'b0, rst_q = 1'b0;
    logic btnC = 1'b0, btnU = 1'b0, btnL = 1'b0, btnR = 1'b0, btnD = 1'b0;
    logic [4:0] held, press, released, long_press, raw_q = '0;
    logic chord_uc;
    int vectors = 0, miscompares = 0, cyc = 0;

    button_event_decoder #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .btnC(btnC), .btnU(btnU), .btnL(btnL), .btnR(btnR), .btnD(btnD),
        .held(held), .press(press), .released(released),
        .long_press(long_press), .chord_uc(chord_uc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
        raw_q <= {btnD, btnR, btnL, btnU, btnC};
    end

    // Model: a button flips its debounced level after D+1 consecutive synced
    // samples that disagree with it; hold time counts agreeing samples while held.
    logic [4:0] s1 = '0, s2 = '0, sv, lvl = '0, m_press = '0, m_rel = '0, m_long = '0;
    logic m_chord = 1'b0, lvl0;
    int run [5];
    int hc [5];

    initial forever begin
        @(negedge clk);
        if (!rst_n || !rst_q) begin
            s1 = '0; s2 = '0; lvl = '0;
            m_press = '0; m_rel = '0; m_long = '0; m_chord = 1'b0;
            for (int b = 0; b < 5; b++) begin
                run[b] = 0;
                hc[b]  = 0;
            end
        end else begin
            sv = s2; s2 = s1; s1 = raw_q;
            lvl0 = lvl[0];
            m_press = '0; m_rel = '0; m_long = '0;
            for (int b = 0; b < 5; b++) begin
                if (sv[b] != lvl[b]) begin
                    run[b]++;
                    if (run[b] == D + 1) begin
                        lvl[b] = sv[b];
                        run[b] = 0;
                        if (sv[b]) begin
                            m_press[b] = 1'b1;
                            hc[b] = 0;
                        end else m_rel[b] = 1'b1;
                    end
                end else begin
                    if (lvl[b] && run[b] == 0 && hc[b] < L - 1) begin
                        hc[b]++;
                        m_long[b] = (hc[b] == L - 1);
                    end
                    run[b] = 0;
                end
            end
            m_chord = m_press[1] & lvl0;
        end
        vectors++;
        if ({held, press, released, long_press, chord_uc} !== {lvl, m_press, m_rel, m_long, m_chord}) begin
            miscompares++;
            $display("FAIL model cycle %0d: got held=%b press=%b release=%b long=%b chord=%b, want held=%b press=%b release=%b long=%b chord=%b",
                     cyc, held, press, released, long_press, chord_uc, lvl, m_press, m_rel, m_long, m_chord);
        end
    end

    // Pulse log for literal timing checks
    int np [5], nr [5], nl [5], pc [5], rc [5], lc [5];
    int nch = 0, chc = 0;

    initial forever begin
        @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            if (press[b])      begin np[b]++; pc[b] = cyc; end
            if (released[b])   begin nr[b]++; rc[b] = cyc; end
            if (long_press[b]) begin nl[b]++; lc[b] = cyc; end
        end
        if (chord_uc) begin nch++; chc = cyc; end
    end

    task automatic clear_log();
        for (int b = 0; b < 5; b++) begin
            np[b] = 0; nr[b] = 0; nl[b] = 0; pc[b] = 0; rc[b] = 0; lc[b] = 0;
        end
        nch = 0;
        chc = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    int s, r;

    initial begin
        clear_log();
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", int'({held, press, released, long_press, chord_uc}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick(3);

        // clean press of U
        clear_log();
        btnU = 1'b1; s = cyc;
        tick(6);
        check("u_press_early", int'(press), 0);
        tick(1);
        check("u_press", int'(press), 5'b00010);
        check("u_held", int'(held), 5'b00010);
        tick(1);
        check("u_press_one_cycle", int'(press), 0);
        check("u_held_stays", int'(held), 5'b00010);
        btnU = 1'b0; s = cyc;
        tick(10);
        check("u_release_count", nr[1], 1);
        check("u_release_latency", rc[1] - s, 7);
        check("u_held_cleared", int'(held), 0);

        // bouncing L
        clear_log();
        for (int i = 0; i < 10; i++) begin
            btnL = ~btnL;
            tick(2);
        end
        check("l_bounce_no_press", np[2], 0);
        btnL = 1'b1; s = cyc;
        tick(12);
        check("l_press_count", np[2], 1);
        check("l_press_latency", pc[2] - s, 7);
        btnL = 1'b0;
        tick(10);

        // long hold of D
        clear_log();
        btnD = 1'b1; s = cyc;
        tick(40);
        btnD = 1'b0; r = cyc;
        tick(10);
        check("d_press_count", np[4], 1);
        check("d_press_latency", pc[4] - s, 7);
        check("d_long_count", nl[4], 1);
        check("d_long_after_press", lc[4] - pc[4], 19);
        check("d_release_count", nr[4], 1);
        check("d_release_latency", rc[4] - r, 7);

        // chord: C accepted first, then U
        clear_log();
        btnC = 1'b1;
        tick(10);
        btnU = 1'b1; s = cyc;
        tick(10);
        check("chord_count", nch, 1);
        check("chord_with_u_press", chc - pc[1], 0);
        check("chord_u_latency", pc[1] - s, 7);
        btnC = 1'b0; btnU = 1'b0;
        tick(10);

        // simultaneous C and U
        clear_log();
        btnC = 1'b1; btnU = 1'b1;
        tick(10);
        check("simul_c_press", np[0], 1);
        check("simul_u_press", np[1], 1);
        check("simul_same_cycle", pc[1] - pc[0], 0);
        check("simul_no_chord", nch, 0);
        btnC = 1'b0; btnU = 1'b0;
        tick(10);

        // reset during PRESS_WAIT of R while C is held
        clear_log();
        btnC = 1'b1;
        tick(10);
        check("pre_reset_held", int'(held), 5'b00001);
        btnR = 1'b1;
        tick(4);
        #1 rst_n = 1'b0;
        #1 check("reset_async_clear", int'({held, press, released, long_press, chord_uc}), 0);
        @(posedge clk);
        #2 rst_n = 1'b1; r = cyc;
        tick(12);
        check("r_press_after_reset", pc[3] - r, 7);
        check("r_press_count", np[3], 1);
        check("c_repress_after_reset", pc[0] - r, 7);
        btnC = 1'b0; btnR = 1'b0;
        tick(10);

        // two-cycle release glitch on C
        clear_log();
        btnC = 1'b1;
        tick(12);
        btnC = 1'b0;
        tick(2);
        btnC = 1'b1;
        tick(30);
        check("glitch_no_release", nr[0], 0);
        check("glitch_held", int'(held[0]), 1);
        check("glitch_long_count", nl[0], 1);
        check("glitch_long_delay", lc[0] - pc[0], 22);
        btnC = 1'b0;
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
